// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: per-requester 1-entry buffers, round-robin drain onto a
// single registered write port, pending-write scoreboard and a flush/drain sequencer.
//
// state | meaning
// RUN   | buffers accept new writebacks, arbiter drains
// DRAIN | accepting stopped, arbiter keeps draining buffers and the grant stage
// DONE  | everything written; flush_done pulses for this one cycle
module rf_wb_arbiter #(
    parameter int NREQ   = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*ADDR_W-1:0]   req_dest,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_dest,
    input  logic [ADDR_W-1:0]        rd_addr1,
    input  logic [ADDR_W-1:0]        rd_addr2,
    output logic                     rd_busy1,
    output logic                     rd_busy2,
    input  logic                     flush,
    output logic                     flush_done,
    output logic                     rg_wrt_en,
    output logic [ADDR_W-1:0]        rg_wrt_dest,
    output logic [DATA_W-1:0]        rg_wrt_data
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NREG  = 2 ** ADDR_W;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]        state;
    logic [NREQ-1:0]   buf_full;
    logic [ADDR_W-1:0] buf_dest [NREQ];
    logic [DATA_W-1:0] buf_data [NREQ];
    logic [IDX_W-1:0]  rr_ptr;

    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;

    logic              g_valid;
    logic [ADDR_W-1:0] g_dest;
    logic [DATA_W-1:0] g_data;
    logic              wr_fire;

    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt;

    // Scan downward from the farthest candidate so the one nearest rr_ptr is left as the winner.
    always_comb begin
        int               j;
        logic [IDX_W-1:0] cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        j           = 0;
        cand        = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            cand = IDX_W'(j);
            if (buf_full[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = (state == ST_RUN) &&
                           (!buf_full[i] || (grant_valid && grant_idx == IDX_W'(i)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full <= '0;
            for (int i = 0; i < NREQ; i++) begin
                buf_dest[i] <= '0;
                buf_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    buf_full[i] <= 1'b1;
                    buf_dest[i] <= req_dest[i*ADDR_W +: ADDR_W];
                    buf_data[i] <= req_data[i*DATA_W +: DATA_W];
                end else if (grant_valid && grant_idx == IDX_W'(i)) begin
                    buf_full[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_valid) begin
            rr_ptr <= (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // The granted entry waits one cycle in the grant stage before reaching the write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_valid <= 1'b0;
            g_dest  <= '0;
            g_data  <= '0;
        end else begin
            g_valid <= grant_valid;
            if (grant_valid) begin
                g_dest <= buf_dest[grant_idx];
                g_data <= buf_data[grant_idx];
            end
        end
    end

    assign wr_fire = g_valid && (g_dest != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rg_wrt_en   <= 1'b0;
            rg_wrt_dest <= '0;
            rg_wrt_data <= '0;
        end else begin
            rg_wrt_en <= wr_fire;
            if (wr_fire) begin
                rg_wrt_dest <= g_dest;
                rg_wrt_data <= g_data;
            end
        end
    end

    // A new issue to the same register outranks the retiring write.
    always_comb begin
        busy_nxt = busy;
        if (wr_fire) begin
            busy_nxt[g_dest] = 1'b0;
        end
        if (iss_valid && iss_dest != '0) begin
            busy_nxt[iss_dest] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign rd_busy1 = busy[rd_addr1];
    assign rd_busy2 = busy[rd_addr2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:   if (flush) state <= ST_DRAIN;
                ST_DRAIN: if (!(|buf_full) && !grant_valid && !g_valid) state <= ST_DONE;
                ST_DONE:  state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

    assign flush_done = (state == ST_DONE);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (NREQ=2, DATA_W=32, ADDR_W=5) with hand-computed expectations.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [9:0]  req_dest;
    logic [63:0] req_data;
    logic        iss_valid;
    logic [4:0]  iss_dest;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic        rd_busy1;
    logic        rd_busy2;
    logic        flush;
    logic        flush_done;
    logic        rg_wrt_en;
    logic [4:0]  rg_wrt_dest;
    logic [31:0] rg_wrt_data;

    int n_cmp = 0;
    int n_err = 0;

    rf_wb_arbiter #(.NREQ(2), .DATA_W(32), .ADDR_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_dest    (req_dest),
        .req_data    (req_data),
        .iss_valid   (iss_valid),
        .iss_dest    (iss_dest),
        .rd_addr1    (rd_addr1),
        .rd_addr2    (rd_addr2),
        .rd_busy1    (rd_busy1),
        .rd_busy2    (rd_busy2),
        .flush       (flush),
        .flush_done  (flush_done),
        .rg_wrt_en   (rg_wrt_en),
        .rg_wrt_dest (rg_wrt_dest),
        .rg_wrt_data (rg_wrt_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_dest  = '0;
        req_data  = '0;
        iss_valid = 1'b0;
        iss_dest  = '0;
        rd_addr1  = '0;
        rd_addr2  = '0;
        flush     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (req_ready !== 2'b11) begin n_err++; $display("FAIL reset_ready got=%b exp=11", req_ready); end
        n_cmp++; if (rg_wrt_en !== 1'b0) begin n_err++; $display("FAIL reset_en got=%b exp=0", rg_wrt_en); end
        n_cmp++; if (rg_wrt_dest !== 5'd0) begin n_err++; $display("FAIL reset_dest got=%0d exp=0", rg_wrt_dest); end
        n_cmp++; if (rg_wrt_data !== 32'h0) begin n_err++; $display("FAIL reset_data got=%h exp=0", rg_wrt_data); end
        n_cmp++; if (flush_done !== 1'b0) begin n_err++; $display("FAIL reset_flush_done got=%b exp=0", flush_done); end
        n_cmp++; if ({rd_busy1, rd_busy2} !== 2'b00) begin n_err++; $display("FAIL reset_busy got=%b exp=00", {rd_busy1, rd_busy2}); end
    endtask

    task automatic test_single_write();
        do_reset();
        req_valid = 2'b01;
        req_dest[4:0] = 5'd5;
        req_data[31:0] = 32'hDEADBEEF;
        tick();
        req_valid = 2'b00;
        n_cmp++; if (rg_wrt_en !== 1'b0) begin n_err++; $display("FAIL single_e1_en got=%b exp=0", rg_wrt_en); end
        tick();
        n_cmp++; if (rg_wrt_en !== 1'b0) begin n_err++; $display("FAIL single_e2_en got=%b exp=0", rg_wrt_en); end
        tick();
        n_cmp++; if (rg_wrt_en !== 1'b1) begin n_err++; $display("FAIL single_e3_en got=%b exp=1", rg_wrt_en); end
        n_cmp++; if (rg_wrt_dest !== 5'd5) begin n_err++; $display("FAIL single_e3_dest got=%0d exp=5", rg_wrt_dest); end
        n_cmp++; if (rg_wrt_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_e3_data got=%h exp=deadbeef", rg_wrt_data); end
        tick();
        n_cmp++; if (rg_wrt_en !== 1'b0) begin n_err++; $display("FAIL single_e4_en got=%b exp=0", rg_wrt_en); end
        n_cmp++; if (rg_wrt_dest !== 5'd5) begin n_err++; $display("FAIL single_e4_dest_hold got=%0d exp=5", rg_wrt_dest); end
    endtask

    task automatic test_contention();
        logic [1:0]  exp_ready;
        logic [4:0]  exp_dest;
        logic [31:0] exp_data;
        int          ones0;
        int          ones1;
        do_reset();
        ones0 = 0;
        ones1 = 0;
        req_valid = 2'b11;
        req_dest  = {5'd4, 5'd3};
        req_data  = {32'h4444_0000, 32'h3333_0000};
        tick();
        for (int k = 0; k < 6; k++) begin
            exp_ready = (k % 2 == 0) ? 2'b01 : 2'b10;
            n_cmp++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL contend_ready k=%0d got=%b exp=%b", k, req_ready, exp_ready); end
            if (k < 4) begin
                ones0 += int'(req_ready[0]);
                ones1 += int'(req_ready[1]);
            end
            if (k >= 2) begin
                exp_dest = (k % 2 == 0) ? 5'd3 : 5'd4;
                exp_data = (k % 2 == 0) ? 32'h3333_0000 : 32'h4444_0000;
                n_cmp++; if (rg_wrt_en !== 1'b1) begin n_err++; $display("FAIL contend_en k=%0d got=%b exp=1", k, rg_wrt_en); end
                n_cmp++; if (rg_wrt_dest !== exp_dest) begin n_err++; $display("FAIL contend_dest k=%0d got=%0d exp=%0d", k, rg_wrt_dest, exp_dest); end
                n_cmp++; if (rg_wrt_data !== exp_data) begin n_err++; $display("FAIL contend_data k=%0d got=%h exp=%h", k, rg_wrt_data, exp_data); end
            end
            tick();
        end
        req_valid = 2'b00;
        n_cmp++; if (ones0 !== 2 || ones1 !== 2) begin n_err++; $display("FAIL contend_duty got=%0d/%0d exp=2/2", ones0, ones1); end
    endtask

    task automatic test_x0_drop();
        do_reset();
        req_valid = 2'b10;
        req_dest[9:5] = 5'd9;
        req_data[63:32] = 32'h0000_0099;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        n_cmp++; if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== 5'd9) begin n_err++; $display("FAIL x0_pre_write got en=%b dest=%0d exp en=1 dest=9", rg_wrt_en, rg_wrt_dest); end
        req_valid = 2'b10;
        req_dest[9:5] = 5'd0;
        req_data[63:32] = 32'h0000_1234;
        tick();
        req_valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if (rg_wrt_en !== 1'b0) begin n_err++; $display("FAIL x0_en k=%0d got=%b exp=0", k, rg_wrt_en); end
            n_cmp++; if (rg_wrt_dest !== 5'd9 || rg_wrt_data !== 32'h99) begin n_err++; $display("FAIL x0_hold k=%0d got dest=%0d data=%h exp dest=9 data=99", k, rg_wrt_dest, rg_wrt_data); end
        end
        n_cmp++; if (req_ready !== 2'b11) begin n_err++; $display("FAIL x0_freed got=%b exp=11", req_ready); end
    endtask

    task automatic test_scoreboard();
        do_reset();
        rd_addr1  = 5'd7;
        rd_addr2  = 5'd8;
        iss_valid = 1'b1;
        iss_dest  = 5'd7;
        #1;
        n_cmp++; if (rd_busy1 !== 1'b0) begin n_err++; $display("FAIL sb_no_bypass got=%b exp=0", rd_busy1); end
        tick();
        iss_valid = 1'b0;
        n_cmp++; if (rd_busy1 !== 1'b1 || rd_busy2 !== 1'b0) begin n_err++; $display("FAIL sb_set got=%b%b exp=10", rd_busy1, rd_busy2); end
        req_valid = 2'b01;
        req_dest[4:0] = 5'd7;
        req_data[31:0] = 32'h77;
        tick();
        req_valid = 2'b00;
        n_cmp++; if (rd_busy1 !== 1'b1) begin n_err++; $display("FAIL sb_held_a got=%b exp=1", rd_busy1); end
        tick();
        n_cmp++; if (rd_busy1 !== 1'b1 || rg_wrt_en !== 1'b0) begin n_err++; $display("FAIL sb_held_b got busy=%b en=%b exp busy=1 en=0", rd_busy1, rg_wrt_en); end
        tick();
        n_cmp++; if (rg_wrt_en !== 1'b1 || rd_busy1 !== 1'b0) begin n_err++; $display("FAIL sb_clear got en=%b busy=%b exp en=1 busy=0", rg_wrt_en, rd_busy1); end
        req_valid = 2'b01;
        req_data[31:0] = 32'h78;
        tick();
        req_valid = 2'b00;
        tick();
        iss_valid = 1'b1;
        iss_dest  = 5'd7;
        tick();
        iss_valid = 1'b0;
        n_cmp++; if (rg_wrt_en !== 1'b1 || rd_busy1 !== 1'b1) begin n_err++; $display("FAIL sb_set_wins got en=%b busy=%b exp en=1 busy=1", rg_wrt_en, rd_busy1); end
        rd_addr2  = 5'd0;
        iss_valid = 1'b1;
        iss_dest  = 5'd0;
        tick();
        iss_valid = 1'b0;
        n_cmp++; if (rd_busy2 !== 1'b0) begin n_err++; $display("FAIL sb_reg0 got=%b exp=0", rd_busy2); end
    endtask

    task automatic test_flush();
        do_reset();
        req_valid = 2'b11;
        req_dest  = {5'd11, 5'd10};
        req_data  = {32'hBBBB_0011, 32'hAAAA_0010};
        tick();
        req_valid = 2'b00;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        req_valid = 2'b01;
        req_dest[4:0] = 5'd12;
        n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL flush_ready_drain got=%b exp=00", req_ready); end
        tick();
        n_cmp++; if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== 5'd10 || flush_done !== 1'b0) begin n_err++; $display("FAIL flush_w1 got en=%b dest=%0d done=%b exp 1/10/0", rg_wrt_en, rg_wrt_dest, flush_done); end
        tick();
        n_cmp++; if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== 5'd11 || flush_done !== 1'b0) begin n_err++; $display("FAIL flush_w2 got en=%b dest=%0d done=%b exp 1/11/0", rg_wrt_en, rg_wrt_dest, flush_done); end
        n_cmp++; if (rg_wrt_data !== 32'hBBBB_0011) begin n_err++; $display("FAIL flush_w2_data got=%h exp=bbbb0011", rg_wrt_data); end
        tick();
        n_cmp++; if (flush_done !== 1'b1 || rg_wrt_en !== 1'b0 || req_ready !== 2'b00) begin n_err++; $display("FAIL flush_done got done=%b en=%b ready=%b exp 1/0/00", flush_done, rg_wrt_en, req_ready); end
        req_valid = 2'b00;
        tick();
        n_cmp++; if (flush_done !== 1'b0 || req_ready !== 2'b11) begin n_err++; $display("FAIL flush_run got done=%b ready=%b exp 0/11", flush_done, req_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (rg_wrt_en !== 1'b0) begin n_err++; $display("FAIL flush_no_extra k=%0d got=%b exp=0", k, rg_wrt_en); end
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (flush_done !== 1'b0 || req_ready !== 2'b00) begin n_err++; $display("FAIL flush_empty_drain got done=%b ready=%b exp 0/00", flush_done, req_ready); end
        tick();
        n_cmp++; if (flush_done !== 1'b1) begin n_err++; $display("FAIL flush_empty_done got=%b exp=1", flush_done); end
        tick();
        n_cmp++; if (flush_done !== 1'b0 || req_ready !== 2'b11) begin n_err++; $display("FAIL flush_empty_run got done=%b ready=%b exp 0/11", flush_done, req_ready); end
    endtask

    task automatic test_async_reset();
        do_reset();
        req_valid = 2'b11;
        req_dest  = {5'd14, 5'd13};
        req_data  = {32'h0E0E_0E0E, 32'h0D0D_0D0D};
        iss_valid = 1'b1;
        iss_dest  = 5'd20;
        rd_addr1  = 5'd20;
        tick();
        req_valid = 2'b00;
        iss_valid = 1'b0;
        tick();
        tick();
        n_cmp++; if (rg_wrt_en !== 1'b1 || rd_busy1 !== 1'b1) begin n_err++; $display("FAIL arst_pre got en=%b busy=%b exp 1/1", rg_wrt_en, rd_busy1); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (rg_wrt_en !== 1'b0 || rg_wrt_dest !== 5'd0 || rg_wrt_data !== 32'h0) begin n_err++; $display("FAIL arst_outputs got en=%b dest=%0d data=%h exp 0/0/0", rg_wrt_en, rg_wrt_dest, rg_wrt_data); end
        n_cmp++; if (rd_busy1 !== 1'b0 || flush_done !== 1'b0) begin n_err++; $display("FAIL arst_sb got busy=%b done=%b exp 0/0", rd_busy1, flush_done); end
        tick();
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if (rg_wrt_en !== 1'b0) begin n_err++; $display("FAIL arst_no_write k=%0d got=%b exp=0", k, rg_wrt_en); end
        end
        n_cmp++; if (req_ready !== 2'b11) begin n_err++; $display("FAIL arst_ready got=%b exp=11", req_ready); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_x0_drop();
        test_scoreboard();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
